// File: rtl/iomem_regbank_pkg.sv
// Shared constants for the iomem register bank: status/control page offsets above the
// game registers and CTRL register bit positions.
package iomem_regbank_pkg;

    localparam int unsigned PAGE_OFS_BTN_LEVEL = 0;
    localparam int unsigned PAGE_OFS_BTN_PRESS = 1;
    localparam int unsigned PAGE_OFS_CTRL      = 2;
    localparam int unsigned NUM_EXTRA_PAGES    = 3;

    localparam int unsigned CTRL_SYNC_EN_BIT = 0;
    localparam int unsigned CTRL_PENDING_BIT = 1;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stability counter and a one-cycle pulse on a
// debounced 0->1 transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flip;

    // Level toggles on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    assign w_flip = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if ((r_sync2 == r_level) || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_flip && !r_level;

endmodule

// File: rtl/iomem_regbank.sv
// PicoSoC iomem register bank: byte-strobed game registers with optional frame-synchronous
// commit, plus debounced button level and sticky press-latch status pages.
module iomem_regbank
    import iomem_regbank_pkg::*;
#(
    parameter int unsigned NUM_REGS        = 8,
    parameter int unsigned REG_W           = 10,
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter logic [7:0]  BASE_PAGE       = 8'h04
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      iomem_valid,
    output logic                      iomem_ready,
    input  logic [3:0]                iomem_wstrb,
    input  logic [31:0]               iomem_addr,
    input  logic [31:0]               iomem_wdata,
    output logic [31:0]               iomem_rdata,
    input  logic [NUM_BTN-1:0]        btn,
    input  logic                      frame_sync,
    output logic [NUM_REGS*REG_W-1:0] reg_out
);

    localparam logic [7:0] PG_LEVEL = 8'(NUM_REGS + PAGE_OFS_BTN_LEVEL);
    localparam logic [7:0] PG_PRESS = 8'(NUM_REGS + PAGE_OFS_BTN_PRESS);
    localparam logic [7:0] PG_CTRL  = 8'(NUM_REGS + PAGE_OFS_CTRL);
    localparam logic [7:0] PG_END   = 8'(NUM_REGS + NUM_EXTRA_PAGES);

    logic                             r_ready;
    logic [31:0]                      r_rdata;
    logic [NUM_REGS*REG_W-1:0]        r_shadow;
    logic [NUM_REGS*REG_W-1:0]        r_reg_out;
    logic                             r_sync_en;
    logic                             r_pending;
    logic [NUM_BTN-1:0]               r_press;

    logic [7:0]                       w_page;
    logic                             w_acc;
    logic                             w_wr;
    logic                             w_ctrl_wr;
    logic                             w_press_rd;
    logic [REG_W-1:0]                 w_lane_mask;
    logic [NUM_REGS-1:0]              w_reg_wr;
    logic [NUM_REGS*REG_W-1:0]        w_shadow_d;
    logic [NUM_REGS:0][REG_W-1:0]     w_rd_chain;
    logic [31:0]                      w_rdata;
    logic [NUM_BTN-1:0]               w_level;
    logic [NUM_BTN-1:0]               w_rise;
    logic                             w_unused;

    // Page arithmetic wraps, so pages below BASE_PAGE land far above PG_END.
    assign w_page     = iomem_addr[31:24] - BASE_PAGE;
    assign w_acc      = iomem_valid && !r_ready && (w_page < PG_END);
    assign w_wr       = |iomem_wstrb;
    assign w_ctrl_wr  = w_acc && (w_page == PG_CTRL) && iomem_wstrb[0];
    assign w_press_rd = w_acc && (w_page == PG_PRESS) && !w_wr;
    assign w_unused   = ^{iomem_addr[23:0], iomem_wdata};

    for (genvar b = 0; b < REG_W; b++) begin : g_lane
        assign w_lane_mask[b] = iomem_wstrb[b / 8];
    end

    assign w_rd_chain[0] = '0;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic w_sel;
        assign w_sel       = (w_page == 8'(i));
        assign w_reg_wr[i] = w_acc && w_wr && w_sel;
        assign w_shadow_d[i*REG_W +: REG_W] = w_reg_wr[i]
            ? ((r_shadow[i*REG_W +: REG_W] & ~w_lane_mask) |
               (iomem_wdata[REG_W-1:0] & w_lane_mask))
            : r_shadow[i*REG_W +: REG_W];
        assign w_rd_chain[i+1] = w_rd_chain[i] | (w_sel ? r_shadow[i*REG_W +: REG_W] : '0);
    end

    for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .resetn (resetn),
            .i_btn  (btn[k]),
            .o_level(w_level[k]),
            .o_rise (w_rise[k])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_page < 8'(NUM_REGS)) begin
            w_rdata[REG_W-1:0] = w_rd_chain[NUM_REGS];
        end else if (w_page == PG_LEVEL) begin
            w_rdata[NUM_BTN-1:0] = w_level;
        end else if (w_page == PG_PRESS) begin
            w_rdata[NUM_BTN-1:0] = r_press;
        end else if (w_page == PG_CTRL) begin
            w_rdata[CTRL_SYNC_EN_BIT] = r_sync_en;
            w_rdata[CTRL_PENDING_BIT] = r_pending;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready   <= 1'b0;
            r_rdata   <= '0;
            r_shadow  <= '0;
            r_reg_out <= '0;
            r_sync_en <= 1'b0;
            r_pending <= 1'b0;
            r_press   <= '0;
        end else begin
            r_ready  <= w_acc;
            if (w_acc) begin
                r_rdata <= w_rdata;
            end
            r_shadow <= w_shadow_d;
            // Commit uses pre-edge shadows, so a same-cycle write waits for the next frame.
            if (!r_sync_en || frame_sync) begin
                r_reg_out <= r_shadow;
            end
            if (!r_sync_en) begin
                r_pending <= 1'b0;
            end else if (|w_reg_wr) begin
                r_pending <= 1'b1;
            end else if (frame_sync) begin
                r_pending <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_sync_en <= iomem_wdata[CTRL_SYNC_EN_BIT];
            end
            r_press <= (w_press_rd ? '0 : r_press) | w_rise;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign reg_out     = r_reg_out;

endmodule

// File: tb/tb_iomem_regbank.sv
// Bench for iomem_regbank: directed scenarios plus random bus/button/frame traffic, all
// compared every cycle against a page-level behavioural model.
module tb_iomem_regbank;

    localparam int NR = 8;
    localparam int RW = 10;
    localparam int NB = 4;
    localparam int DB = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              iomem_valid = 1'b0;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb = 4'h0;
    logic [31:0]       iomem_addr = 32'h0;
    logic [31:0]       iomem_wdata = 32'h0;
    logic [31:0]       iomem_rdata;
    logic [NB-1:0]     btn = '0;
    logic              frame_sync = 1'b0;
    logic [NR*RW-1:0]  reg_out;

    iomem_regbank #(
        .NUM_REGS       (NR),
        .REG_W          (RW),
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .BASE_PAGE      (8'h04)
    ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .btn        (btn),
        .frame_sync (frame_sync),
        .reg_out    (reg_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural model: page-level view of the bank.
    logic [RW-1:0] m_sh [NR];
    logic [RW-1:0] m_out[NR];
    bit            m_sync, m_pend, m_ready;
    logic [31:0]   m_rdata;
    logic [NB-1:0] m_h1, m_h2, m_lvl, m_press;
    int            m_cnt[NB];

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_sh[i]  = '0;
            m_out[i] = '0;
        end
        for (int b = 0; b < NB; b++) m_cnt[b] = 0;
        m_sync = 0; m_pend = 0; m_ready = 0; m_rdata = '0;
        m_h1 = '0; m_h2 = '0; m_lvl = '0; m_press = '0;
    endtask

    task automatic model_step();
        int            p;
        bit            acc, wr;
        logic [NB-1:0] rise;
        p   = int'(iomem_addr[31:24]) - 4;
        acc = iomem_valid && !m_ready && p >= 0 && p < NR + 3;
        wr  = iomem_wstrb != 4'h0;
        if (acc) begin
            if (p < NR)           m_rdata = 32'(m_sh[p]);
            else if (p == NR)     m_rdata = 32'(m_lvl);
            else if (p == NR + 1) m_rdata = 32'(m_press);
            else                  m_rdata = {30'b0, m_pend, m_sync};
        end
        if (!m_sync || frame_sync) m_out = m_sh;
        if (!m_sync) m_pend = 0;
        else if (acc && wr && p < NR) m_pend = 1;
        else if (frame_sync) m_pend = 0;
        if (acc && wr && p < NR)
            for (int k = 0; k < RW; k++) if (iomem_wstrb[k/8]) m_sh[p][k] = iomem_wdata[k];
        if (acc && p == NR + 2 && iomem_wstrb[0]) m_sync = iomem_wdata[0];
        rise = '0;
        for (int b = 0; b < NB; b++) begin
            if (m_h2[b] != m_lvl[b]) begin
                m_cnt[b]++;
                if (m_cnt[b] == DB) begin
                    m_lvl[b] = m_h2[b];
                    rise[b]  = m_h2[b];
                    m_cnt[b] = 0;
                end
            end else begin
                m_cnt[b] = 0;
            end
        end
        if (acc && p == NR + 1 && !wr) m_press = rise;
        else m_press = m_press | rise;
        m_h2    = m_h1;
        m_h1    = btn;
        m_ready = acc;
    endtask

    function automatic logic [NR*RW-1:0] model_out();
        logic [NR*RW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = m_out[i];
        return v;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
            #1;
            check("cyc_ready", 128'(iomem_ready), 128'(m_ready));
            check("cyc_rdata", 128'(iomem_rdata), 128'(m_rdata));
            check("cyc_reg_out", 128'(reg_out), 128'(model_out()));
        end
    end

    task automatic bus(input logic [7:0] page, input logic [3:0] strb, input logic [31:0] wd,
                       input bit fs, output logic [31:0] rd);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = {page, 24'h0};
        iomem_wstrb = strb;
        iomem_wdata = wd;
        frame_sync  = fs;
        @(posedge clk);
        #1;
        check("ack", 128'(iomem_ready), 128'd1);
        rd = iomem_rdata;
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        frame_sync  = 1'b0;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    logic [31:0] rd;
    int          seen;
    int          hold;

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        check("rst_reg_out", 128'(reg_out), 128'd0);
        bus(8'h04, 4'h0, 32'h0, 0, rd);
        check("rd_page4", 128'(rd), 128'd0);

        bus(8'h06, 4'b0011, 32'h3FF, 0, rd);
        @(posedge clk); #1;
        check("wr_3ff", 128'(reg_out[29:20]), 128'h3FF);
        bus(8'h06, 4'b0001, 32'h155, 0, rd);
        @(posedge clk); #1;
        check("wr_lane0", 128'(reg_out[29:20]), 128'h355);

        bus(8'h0E, 4'b0001, 32'h1, 0, rd);
        bus(8'h04, 4'b1111, 32'h96, 0, rd);
        @(posedge clk); #1;
        check("sync_hold", 128'(reg_out[9:0]), 128'h0);
        bus(8'h0E, 4'h0, 32'h0, 0, rd);
        check("ctrl_pend", 128'(rd), 128'h3);
        frame_pulse();
        check("sync_commit", 128'(reg_out[9:0]), 128'h96);
        bus(8'h0E, 4'h0, 32'h0, 0, rd);
        check("ctrl_clear", 128'(rd), 128'h1);
        bus(8'h04, 4'b1111, 32'h2A, 1, rd);
        @(posedge clk); #1;
        check("fs_same_cyc", 128'(reg_out[9:0]), 128'h96);
        bus(8'h0E, 4'h0, 32'h0, 0, rd);
        check("fs_same_pend", 128'(rd), 128'h3);
        frame_pulse();
        check("fs_next", 128'(reg_out[9:0]), 128'h2A);

        bus(8'h04, 4'b1111, 32'h111, 0, rd);
        bus(8'h0E, 4'b0001, 32'h0, 0, rd);
        @(posedge clk); #1;
        check("force_commit", 128'(reg_out[9:0]), 128'h111);

        @(negedge clk); btn = 4'b0100;
        repeat (3) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        bus(8'h0C, 4'h0, 32'h0, 0, rd);
        check("glitch_lvl", 128'(rd), 128'h0);
        bus(8'h0D, 4'h0, 32'h0, 0, rd);
        check("glitch_press", 128'(rd), 128'h0);
        @(negedge clk); btn = 4'b0100;
        repeat (8) @(negedge clk);
        bus(8'h0C, 4'h0, 32'h0, 0, rd);
        check("hold_lvl", 128'(rd), 128'h4);
        bus(8'h0D, 4'h0, 32'h0, 0, rd);
        check("hold_press", 128'(rd), 128'h4);
        bus(8'h0D, 4'h0, 32'h0, 0, rd);
        check("press_cleared", 128'(rd), 128'h0);
        @(negedge clk); btn = 4'b0000;
        repeat (10) @(negedge clk);

        // btn[1] debounced rise lands on the same edge as the clearing read.
        @(negedge clk); btn = 4'b0010;
        repeat (4) @(negedge clk);
        bus(8'h0D, 4'h0, 32'h0, 0, rd);
        check("race_read", 128'(rd), 128'h0);
        bus(8'h0D, 4'h0, 32'h0, 0, rd);
        check("race_kept", 128'(rd), 128'h2);
        @(negedge clk); btn = 4'b0000;
        repeat (10) @(negedge clk);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h2000_0000;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (iomem_ready) seen++;
        end
        check("unmap_ready", 128'(seen), 128'd0);
        check("unmap_rdata", 128'(iomem_rdata), 128'h2);
        @(negedge clk); iomem_valid = 1'b0;

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h3FF;
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 128'(iomem_ready), 128'd0);
        check("rst_rdata", 128'(iomem_rdata), 128'd0);
        check("rst_out", 128'(reg_out), 128'd0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        #2 resetn = 1'b1;

        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            frame_sync = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 11) == 0) btn = btn ^ (4'b0001 << $urandom_range(0, NB - 1));
            if (iomem_valid) begin
                hold++;
                if (iomem_ready || hold > 3) begin
                    iomem_valid = 1'b0;
                    iomem_wstrb = 4'h0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                hold        = 0;
                iomem_valid = 1'b1;
                iomem_addr  = {8'($urandom_range(3, 16)), 24'($urandom)};
                iomem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                iomem_wdata = $urandom;
            end
        end
        @(negedge clk);
        iomem_valid = 1'b0;
        frame_sync  = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
